// File: rtl/branch_recovery_controller.sv
// Branch recovery sequencer: detects EX-stage mispredicts, redirects fetch and flushes IF/ID + ID/EX.
// Latency: redirect and flush register one edge after acceptance. A stall defers the redirect (PENDING) but never delays an active flush.
module branch_recovery_controller #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_branch,
  input  logic             EX_branch_taken,
  input  logic             EX_pred_taken,
  input  logic [XLEN-1:0]  EX_pc,
  input  logic [XLEN-1:0]  EX_imm,
  input  logic             stall,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_target,
  output logic             predictor_update,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             redirect_q, redirect_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic             mispredict;
  logic [XLEN-1:0]  corr_target;

  assign mispredict  = EX_branch_taken != EX_pred_taken;
  assign corr_target = EX_branch_taken ? (EX_pc + EX_imm) : (EX_pc + PC_STEP);

  // Only branches seen in IDLE without a stall are on the committed path.
  assign predictor_update = EX_branch & (state_q == IDLE) & ~stall;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    flush_d    = 1'b0;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (EX_branch) begin
          if (!stall) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
            if (mispredict) begin
              mp_cnt_d   = mp_cnt_q + CNT_ONE;
              target_d   = corr_target;
              redirect_d = 1'b1;
              flush_d    = 1'b1;
              cnt_d      = FLUSH_INIT;
              state_d    = FLUSH;
            end
          end else if (mispredict) begin
            target_d = corr_target;
            state_d  = PENDING;
          end
        end
      end
      PENDING: begin
        // Statistics are deferred until the held mispredict actually redirects.
        if (!stall) begin
          br_cnt_d   = br_cnt_q + CNT_ONE;
          mp_cnt_d   = mp_cnt_q + CNT_ONE;
          redirect_d = 1'b1;
          flush_d    = 1'b1;
          cnt_d      = FLUSH_INIT;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  assign flush_IF_ID      = flush_q;
  assign flush_ID_EX      = flush_q;
  assign redirect_valid   = redirect_q;
  assign redirect_target  = target_q;
  assign busy             = busy_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule

// File: tb/tb_branch_recovery_controller.sv
// Directed bench for branch_recovery_controller with hand-computed expectations.
module tb_branch_recovery_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_branch, EX_branch_taken, EX_pred_taken, stall;
  logic [31:0] EX_pc, EX_imm;
  logic        flush_IF_ID, flush_ID_EX, redirect_valid, predictor_update, busy;
  logic [31:0] redirect_target, branch_count, mispredict_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_recovery_controller #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .EX_branch(EX_branch), .EX_branch_taken(EX_branch_taken), .EX_pred_taken(EX_pred_taken),
    .EX_pc(EX_pc), .EX_imm(EX_imm), .stall(stall),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .predictor_update(predictor_update), .busy(busy),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic v, input logic pred, input logic taken,
                    input logic [31:0] pc, input logic [31:0] imm);
    EX_branch = v; EX_pred_taken = pred; EX_branch_taken = taken;
    EX_pc = pc; EX_imm = imm;
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic exp);
    chk({tag, ".flush_IF_ID"}, 64'(flush_IF_ID), 64'(exp));
    chk({tag, ".flush_ID_EX"}, 64'(flush_ID_EX), 64'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_flush(tag, 1'b0);
    chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
    chk({tag, ".redirect_target"}, 64'(redirect_target), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".branch_count"}, 64'(branch_count), 64'd0);
    chk({tag, ".mispredict_count"}, 64'(mispredict_count), 64'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    EX_branch = 0; EX_pred_taken = 0; EX_branch_taken = 0; EX_pc = '0; EX_imm = '0;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Two correct branches make the counters nonzero before a second reset
    br(1, 0, 0, 32'h10, 32'h8);
    step(); step();
    br(0, 0, 0, 32'h0, 32'h0);
    chk("pre.branch_count", 64'(branch_count), 64'd2);
    reset = 1'b1; #1;
    chk_all_zero("reset2");
    step(); reset = 1'b0;

    // T1: correct taken branch
    br(1, 1, 1, 32'h200, 32'h20);
    chk("t1.predictor_update", 64'(predictor_update), 64'd1);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t1.branch_count", 64'(branch_count), 64'd1);
    chk("t1.mispredict_count", 64'(mispredict_count), 64'd0);
    chk("t1.redirect_valid", 64'(redirect_valid), 64'd0);
    chk_flush("t1", 1'b0);
    chk("t1.busy", 64'(busy), 64'd0);

    // T2: predicted not-taken, resolved taken
    br(1, 0, 1, 32'h100, 32'h40);
    chk("t2.predictor_update", 64'(predictor_update), 64'd1);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t2.redirect_valid", 64'(redirect_valid), 64'd1);
    chk("t2.redirect_target", 64'(redirect_target), 64'h140);
    chk_flush("t2.c0", 1'b1);
    chk("t2.busy", 64'(busy), 64'd1);
    chk("t2.mispredict_count", 64'(mispredict_count), 64'd1);
    chk("t2.branch_count", 64'(branch_count), 64'd2);
    step();
    chk("t2.redirect_once", 64'(redirect_valid), 64'd0);
    chk_flush("t2.c1", 1'b1);
    step();
    chk_flush("t2.c2", 1'b0);
    chk("t2.busy_end", 64'(busy), 64'd0);

    // T3: predicted taken, resolved not-taken, fall-through wraps to 0
    br(1, 1, 0, 32'hFFFF_FFFC, 32'h1234);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t3.redirect_valid", 64'(redirect_valid), 64'd1);
    chk("t3.redirect_target", 64'(redirect_target), 64'h0);
    chk_flush("t3.c0", 1'b1);
    chk("t3.mispredict_count", 64'(mispredict_count), 64'd2);
    step();
    chk_flush("t3.c1", 1'b1);
    step();
    chk_flush("t3.c2", 1'b0);
    chk("t3.busy_end", 64'(busy), 64'd0);

    // Correct branch under stall is dropped entirely
    stall = 1'b1;
    br(1, 1, 1, 32'h600, 32'h4);
    chk("st.predictor_update", 64'(predictor_update), 64'd0);
    step();
    chk("st.busy", 64'(busy), 64'd0);
    chk("st.branch_count", 64'(branch_count), 64'd3);

    // T4: mispredict under a 3-cycle stall; a different branch is driven while PENDING
    br(1, 0, 1, 32'h300, 32'h10);
    step();
    br(1, 1, 0, 32'h500, 32'h4);
    chk("t4.busy", 64'(busy), 64'd1);
    chk("t4.redirect_valid", 64'(redirect_valid), 64'd0);
    chk_flush("t4.pend", 1'b0);
    chk("t4.branch_count", 64'(branch_count), 64'd3);
    chk("t4.mispredict_count", 64'(mispredict_count), 64'd2);
    chk("t4.pu_pending", 64'(predictor_update), 64'd0);
    step(); step();
    stall = 1'b0; #1;
    chk("t4.pu_release", 64'(predictor_update), 64'd0);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t4.redirect_valid", 64'(redirect_valid), 64'd1);
    chk("t4.redirect_target", 64'(redirect_target), 64'h310);
    chk_flush("t4.c0", 1'b1);
    chk("t4.branch_count_rel", 64'(branch_count), 64'd4);
    chk("t4.mispredict_count_rel", 64'(mispredict_count), 64'd3);
    step();
    chk_flush("t4.c1", 1'b1);
    step();
    chk_flush("t4.c2", 1'b0);
    chk("t4.busy_end", 64'(busy), 64'd0);

    // T5: wrong-path mispredict during FLUSH, then accepted right after FLUSH ends
    br(1, 0, 1, 32'h400, 32'h8);
    step();
    br(1, 0, 1, 32'h800, 32'h4);
    chk("t5.pu_flush", 64'(predictor_update), 64'd0);
    step();
    chk("t5.redirect_valid", 64'(redirect_valid), 64'd0);
    chk("t5.redirect_target", 64'(redirect_target), 64'h408);
    chk("t5.branch_count", 64'(branch_count), 64'd5);
    chk("t5.mispredict_count", 64'(mispredict_count), 64'd4);
    chk_flush("t5.c1", 1'b1);
    step();
    chk_flush("t5.c2", 1'b0);
    chk("t5.pu_b2b", 64'(predictor_update), 64'd1);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t5.b2b_redirect", 64'(redirect_valid), 64'd1);
    chk("t5.b2b_target", 64'(redirect_target), 64'h804);
    chk("t5.b2b_mispredict_count", 64'(mispredict_count), 64'd5);
    step(); step();
    chk("t5.busy_end", 64'(busy), 64'd0);

    // T6: reset during FLUSH, then a clean recovery
    br(1, 0, 1, 32'h1000, 32'h20);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk_flush("t6.pre", 1'b1);
    #1 reset = 1'b1; #1;
    chk_all_zero("t6.rst");
    step(); reset = 1'b0;
    br(1, 0, 1, 32'h2000, 32'h100);
    chk("t6.predictor_update", 64'(predictor_update), 64'd1);
    step(); br(0, 0, 0, 32'h0, 32'h0);
    chk("t6.redirect_valid", 64'(redirect_valid), 64'd1);
    chk("t6.redirect_target", 64'(redirect_target), 64'h2100);
    chk_flush("t6.c0", 1'b1);
    chk("t6.branch_count", 64'(branch_count), 64'd1);
    chk("t6.mispredict_count", 64'(mispredict_count), 64'd1);
    step();
    chk_flush("t6.c1", 1'b1);
    step();
    chk_flush("t6.c2", 1'b0);
    chk("t6.busy_end", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
